// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN-to-1 multiplexer: a binary tree of 2-to-1 levels with a register
// after every level and valid/ready flow control on both ends.
module mux_tree_pipe #(
  parameter int WIDTH  = 4,
  parameter int N_IN   = 8,
  parameter int SEL_W  = $clog2(N_IN),
  parameter int LEVELS = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_select,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // can_load[k]: stage k may capture this cycle; can_load[LEVELS] is the consumer.
  logic [LEVELS:0]   can_load;
  logic [LEVELS-1:0] valid_vec;

  // A stage may load when it is empty or is handing its item on. Walking from the
  // output backwards lets bubbles collapse during a stall.
  always_comb begin
    // NOTE: give every combinationally written signal a default first so no path leaves it unassigned (no latch).
    can_load         = '0;
    can_load[LEVELS] = out_ready;
    for (int k = LEVELS - 1; k >= 0; k--)
      can_load[k] = !valid_vec[k] | can_load[k+1];
  end

  assign in_ready = can_load[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NE = N_IN >> (k + 1);

    logic [2*NE*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]      src_sel;
    logic                  src_valid;
    logic [NE*WIDTH-1:0]   mux_d;
    logic [NE*WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]      sel_q;
    logic                  valid_q;

    if (k == 0) begin : g_head
      assign src_data  = in_data;
      assign src_sel   = in_select;
      assign src_valid = in_valid;
    end else begin : g_body
      assign src_data  = g_lvl[k-1].data_q;
      assign src_sel   = g_lvl[k-1].sel_q;
      assign src_valid = valid_vec[k-1];
    end

    // Select bit k chooses between adjacent pairs: entry 2j is a, entry 2j+1 is b.
    always_comb begin
      mux_d = '0;
      for (int j = 0; j < NE; j++)
        mux_d[j*WIDTH +: WIDTH] = src_sel[k] ? src_data[(2*j+1)*WIDTH +: WIDTH]
                                             : src_data[2*j*WIDTH +: WIDTH];
    end

    // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        sel_q   <= '0;
      end else if (can_load[k]) begin
        valid_q <= src_valid;
        // Payload only moves with a real item; a bubble leaves stale, unobserved data.
        if (src_valid) begin
          data_q <= mux_d;
          sel_q  <= src_sel;
        end
      end
    end

    assign valid_vec[k] = valid_q;
  end

  assign out_data   = g_lvl[LEVELS-1].data_q;
  assign out_select = g_lvl[LEVELS-1].sel_q;
  assign out_valid  = valid_vec[LEVELS-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: directed flow-control scenarios on the 8x4 build plus
// random traffic on 8x4, 2x1 and 16x8 builds, all scored against a queue model.
module tb_mux_tree_pipe;

  logic clk;
  logic rst_n;
  int   edges;
  int   n_checks;
  int   n_pass;

  // Main instance: N_IN=8, WIDTH=4, latency 3.
  logic [31:0]  m_in_data;
  logic [2:0]   m_in_select;
  logic         m_in_valid, m_in_ready;
  logic [3:0]   m_out_data;
  logic [2:0]   m_out_select;
  logic         m_out_valid, m_out_ready;

  // Corner instance 1: N_IN=2, WIDTH=1, latency 1.
  logic [1:0]   c1_in_data;
  logic [0:0]   c1_in_select;
  logic         c1_in_valid, c1_in_ready;
  logic [0:0]   c1_out_data;
  logic [0:0]   c1_out_select;
  logic         c1_out_valid, c1_out_ready;

  // Corner instance 2: N_IN=16, WIDTH=8, latency 4.
  logic [127:0] c2_in_data;
  logic [3:0]   c2_in_select;
  logic         c2_in_valid, c2_in_ready;
  logic [7:0]   c2_out_data;
  logic [3:0]   c2_out_select;
  logic         c2_out_valid, c2_out_ready;

  mux_tree_pipe #(.WIDTH(4), .N_IN(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(m_in_data), .in_select(m_in_select), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_data(m_out_data), .out_select(m_out_select), .out_valid(m_out_valid), .out_ready(m_out_ready)
  );

  mux_tree_pipe #(.WIDTH(1), .N_IN(2)) u_c1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(c1_in_data), .in_select(c1_in_select), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .out_data(c1_out_data), .out_select(c1_out_select), .out_valid(c1_out_valid), .out_ready(c1_out_ready)
  );

  mux_tree_pipe #(.WIDTH(8), .N_IN(16)) u_c2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(c2_in_data), .in_select(c2_in_select), .in_valid(c2_in_valid), .in_ready(c2_in_ready),
    .out_data(c2_out_data), .out_select(c2_out_select), .out_valid(c2_out_valid), .out_ready(c2_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edges = 0;
    forever begin
      @(posedge clk);
      edges++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: each DUT is a FIFO of at most LEVELS items. An item becomes
  // visible LEVELS-1 edges after the edge that accepted it, and the head is never
  // blocked by anything ahead of it.
  typedef struct {
    logic [7:0] data;
    logic [7:0] sel;
    int         ready_at;
  } item_t;

  item_t sb[3][$];
  int    xfers[3];

  task automatic score(input int id, input int lv, input int w,
                       input logic [127:0] din, input logic [7:0] sin, input logic vin,
                       input logic rin, input logic [7:0] dout, input logic [7:0] sout,
                       input logic vout, input logic rout);
    logic  exp_rdy, exp_v;
    item_t it;
    exp_rdy = (sb[id].size() < lv) || rout;
    exp_v   = (sb[id].size() != 0) && (sb[id][0].ready_at <= edges);
    check($sformatf("in_ready[%0d]", id), 128'(rin), 128'(exp_rdy));
    check($sformatf("out_valid[%0d]", id), 128'(vout), 128'(exp_v));
    if (exp_v) begin
      check($sformatf("out_data[%0d]", id), 128'(dout), 128'(sb[id][0].data));
      check($sformatf("out_select[%0d]", id), 128'(sout), 128'(sb[id][0].sel));
      if (rout) void'(sb[id].pop_front());
    end
    if (vin && exp_rdy) begin
      it.data     = 8'((din >> (int'(sin) * w)) & ((128'd1 << w) - 128'd1));
      it.sel      = sin;
      it.ready_at = edges + lv;
      sb[id].push_back(it);
      xfers[id]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      score(0, 3, 4, 128'(m_in_data), 8'(m_in_select), m_in_valid, m_in_ready,
            8'(m_out_data), 8'(m_out_select), m_out_valid, m_out_ready);
      score(1, 1, 1, 128'(c1_in_data), 8'(c1_in_select), c1_in_valid, c1_in_ready,
            8'(c1_out_data), 8'(c1_out_select), c1_out_valid, c1_out_ready);
      score(2, 4, 8, c2_in_data, 8'(c2_in_select), c2_in_valid, c2_in_ready,
            c2_out_data, 8'(c2_out_select), c2_out_valid, c2_out_ready);
    end
  end

  // Corner instances see random traffic for the whole run.
  initial begin
    c1_in_data = '0; c1_in_select = '0; c1_in_valid = 1'b0; c1_out_ready = 1'b1;
    c2_in_data = '0; c2_in_select = '0; c2_in_valid = 1'b0; c2_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      c1_in_data   = 2'($urandom);
      c1_in_select = 1'($urandom);
      c1_in_valid  = ($urandom_range(0, 3) != 0);
      c1_out_ready = ($urandom_range(0, 3) != 0);
      c2_in_data   = {$urandom, $urandom, $urandom, $urandom};
      c2_in_select = 4'($urandom);
      c2_in_valid  = ($urandom_range(0, 3) != 0);
      c2_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold one item on the main input until it is accepted (bounded wait).
  task automatic push(input logic [2:0] s, input logic [31:0] d);
    logic done;
    done        = 1'b0;
    m_in_valid  = 1'b1;
    m_in_select = s;
    m_in_data   = d;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      done = m_in_ready;
      step();
    end
    m_in_valid = 1'b0;
    check("push_accept", 128'(done), 128'd1);
  endtask

  logic [31:0] bp_data [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    m_in_data = '0; m_in_select = '0; m_in_valid = 1'b0; m_out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 128'(m_out_valid), 128'd0);
    check("rst_out_data", 128'(m_out_data), 128'd0);
    check("rst_out_select", 128'(m_out_select), 128'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 128'(m_in_ready), 128'd1);
    step();

    // Select sweep: input i carries value i.
    m_in_data   = 32'h7654_3210;
    m_out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      m_in_valid  = 1'b1;
      m_in_select = 3'(s);
      step();
    end
    m_in_valid = 1'b0;
    repeat (5) step();

    // Backpressure: consumer stalls while eight items stream in.
    for (int i = 0; i < 8; i++) bp_data[i] = $urandom;
    fork
      for (int i = 0; i < 8; i++) push(3'(i), bp_data[i]);
      begin
        repeat (3) step();
        m_out_ready = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("bp_in_ready", 128'(m_in_ready), 128'd0);
        check("bp_out_valid", 128'(m_out_valid), 128'd1);
        check("bp_hold_data", 128'(m_out_data), 128'(bp_data[0][3:0]));
        step();
        repeat (3) step();
        m_out_ready = 1'b1;
      end
    join
    repeat (6) step();

    // Bubbles: alternating valid with a free-running consumer.
    m_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_in_valid  = (i % 2 == 0);
      m_in_select = 3'($urandom);
      m_in_data   = $urandom;
      step();
    end
    m_in_valid = 1'b0;
    repeat (5) step();

    // Simultaneous push/pop on a full pipeline.
    m_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(3'($urandom), $urandom);
    @(negedge clk);
    check("full_in_ready", 128'(m_in_ready), 128'd0);
    step();
    m_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_in_valid  = 1'b1;
      m_in_select = 3'($urandom);
      m_in_data   = $urandom;
      @(negedge clk);
      check("pp_in_ready", 128'(m_in_ready), 128'd1);
      check("pp_out_valid", 128'(m_out_valid), 128'd1);
      step();
    end
    m_in_valid = 1'b0;
    repeat (5) step();

    // Reset with three items in flight.
    m_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(3'(i + 4), $urandom | 32'h1111_1111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) sb[i].delete();
    #1;
    check("mid_rst_out_valid", 128'(m_out_valid), 128'd0);
    check("mid_rst_out_data", 128'(m_out_data), 128'd0);
    check("mid_rst_out_select", 128'(m_out_select), 128'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_item", 128'(m_out_valid), 128'd0);
      step();
    end

    // Random traffic on the main instance.
    for (int c = 0; c < 2500; c++) begin
      m_in_valid  = ($urandom_range(0, 3) != 0);
      m_in_select = 3'($urandom);
      m_in_data   = $urandom;
      m_out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("drain_empty", 128'(sb[0].size()), 128'd0);
    check("c1_transfers", 128'(xfers[1] >= 1000), 128'd1);
    check("c2_transfers", 128'(xfers[2] >= 1000), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
